// File: rtl/sdram_writer.sv
// Avalon-MM burst write master: streams 256-bit pixel words into one contiguous SDRAM frame.
// Optional macro SDRAM_WRITER_DBLBUF_EN alternates frames between two buffers and adds frame_buf_o.
module sdram_writer #(
    parameter logic [26:0] FRAME_BASE_ADDR = 27'h0,
    parameter int unsigned FRAME_WORDS     = 259200,
    parameter int unsigned BURST_LEN       = 16
) (
    input  logic           sdram_clk,
    input  logic           rst,
    input  logic           frame_start_i,
    output logic           frame_ready_o,
    output logic           busy_o,
`ifdef SDRAM_WRITER_DBLBUF_EN
    output logic           frame_buf_o,
`endif
    input  logic [255:0]   pixel8_i,
    input  logic           pixel8_valid_i,
    output logic           pixel8_ready_o,
    output logic [26:0]    sdram_address_o,
    output logic [7:0]     sdram_burstcount_o,
    output logic           sdram_write_o,
    output logic [255:0]   sdram_writedata_o,
    output logic [31:0]    sdram_byteenable_o,
    input  logic           sdram_waitrequest_i
);

    localparam int unsigned    RW            = $clog2(FRAME_WORDS + 1);
    localparam logic [RW-1:0]  FRAME_WORDS_R = RW'(FRAME_WORDS);
    localparam logic [7:0]     BURST_LEN_B   = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t         state, state_next;
    logic [26:0]    addr;
    logic [RW-1:0]  remaining;
    logic [7:0]     burst_len;
    logic [7:0]     beat;
    logic [26:0]    base_sel;
    logic           load;
    logic           beat_acc;
    logic           last_beat;
    logic [RW-1:0]  rem_after;

    function automatic logic [7:0] clamp_len(input logic [RW-1:0] rem);
        if (32'(rem) >= BURST_LEN)
            return BURST_LEN_B;
        else
            return 8'(rem);
    endfunction

    assign last_beat = (beat == burst_len - 8'd1);
    assign rem_after = remaining - RW'(burst_len);

    always_ff @(posedge sdram_clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load           = 1'b0;
        beat_acc       = 1'b0;
        busy_o         = 1'b0;
        frame_ready_o  = 1'b0;
        sdram_write_o  = 1'b0;
        pixel8_ready_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start_i) begin
                    load       = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                busy_o         = 1'b1;
                sdram_write_o  = pixel8_valid_i;
                pixel8_ready_o = ~sdram_waitrequest_i;
                beat_acc       = pixel8_valid_i & ~sdram_waitrequest_i;
                if (beat_acc && last_beat && rem_after == '0)
                    state_next = DONE;
            end
            DONE: begin
                frame_ready_o = 1'b1;
                if (frame_start_i) begin
                    load       = 1'b1;
                    state_next = BURST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and burst length only move on the last beat of a burst, so they stay stable across stalls.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            burst_len <= '0;
            beat      <= '0;
        end else if (load) begin
            addr      <= base_sel;
            remaining <= FRAME_WORDS_R;
            burst_len <= clamp_len(FRAME_WORDS_R);
            beat      <= '0;
        end else if (beat_acc) begin
            if (last_beat) begin
                remaining <= rem_after;
                beat      <= '0;
                if (rem_after != '0) begin
                    addr      <= addr + 27'(burst_len);
                    burst_len <= clamp_len(rem_after);
                end
            end else begin
                beat <= beat + 8'd1;
            end
        end
    end

`ifdef SDRAM_WRITER_DBLBUF_EN
    localparam logic [26:0] BASE1 = FRAME_BASE_ADDR + 27'(FRAME_WORDS);
    logic tgt_buf;

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            tgt_buf     <= 1'b0;
            frame_buf_o <= 1'b0;
        end else if (state == BURST && state_next == DONE) begin
            frame_buf_o <= tgt_buf;
            tgt_buf     <= ~tgt_buf;
        end
    end

    assign base_sel = tgt_buf ? BASE1 : FRAME_BASE_ADDR;
`else
    assign base_sel = FRAME_BASE_ADDR;
`endif

    assign sdram_address_o    = addr;
    assign sdram_burstcount_o = burst_len;
    assign sdram_writedata_o  = pixel8_i;
    assign sdram_byteenable_o = '1;

endmodule
